// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] work;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] work_next;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    always_comb begin
        d_bit     = a_sh[0] ^ b_sh[0] ^ borrow;
        br_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        work_next = {d_bit, work};
    end

    // work only holds the bits produced so far; diff is written once, on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            borrow <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    work   <= work_next[WIDTH-1:1];
                    borrow <= br_next;
                    if (cnt == LAST) begin
                        diff  <= work_next;
                        bout  <= br_next;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance for directed/random ops and a 4-bit
// instance for exhaustive back-to-back ops; ovf checks appear when SERIAL_SUB_OVF_EN is set.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;
`ifdef SERIAL_SUB_OVF_EN
    logic ovf8, ovf4;
`endif

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q8[$];
    logic [4:0] exp_q4[$];

    // Every task is entered and left just after a falling edge; inputs change there,
    // outputs are sampled there.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit inject);
        int lat;
        int busy_cnt;
        int sv;
        logic [8:0] exp;
        logic [8:0] got;
        logic exp_ovf;
        exp = {1'b0, a} - {1'b0, b} - 9'(bin);
        exp_q8.push_back(exp);
        sv = int'($signed(a)) - int'($signed(b)) - int'(bin);
        exp_ovf = (sv < -128) || (sv > 127);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            if (inject && lat == 3) begin
                start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; bin8 = 1'b0;
            end else begin
                start8 = 1'b0;
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                bin8 = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        if (busy8 === 1'b1) busy_cnt++;
        vectors++;
        if (lat != 8) begin
            miscompares++;
            $display("FAIL done_latency8: got %0d edges, need 8", lat);
        end
        vectors++;
        if (busy_cnt != 9) begin
            miscompares++;
            $display("FAIL busy_cycles8: got %0d, need 9", busy_cnt);
        end
        got = {bout8, diff8};
        exp = exp_q8.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL result8 a=%0h b=%0h bin=%0b: got {bout,diff}=%h, need %h", a, b, bin, got, exp);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (ovf8 !== exp_ovf) begin
            miscompares++;
            $display("FAIL ovf8 a=%0h b=%0h bin=%0b: got %b, need %b", a, b, bin, ovf8, exp_ovf);
        end
`endif
        @(negedge clk);
        vectors++;
        if ({busy8, done8} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_after8: got busy,done=%b, need 00", {busy8, done8});
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int lat;
        logic [4:0] exp;
        exp_q4.push_back({1'b0, a} - {1'b0, b} - 5'(bin));
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        exp = exp_q4.pop_front();
        vectors++;
        if (lat != 4 || {bout4, diff4} !== exp) begin
            miscompares++;
            $display("FAIL result4 a=%0h b=%0h bin=%0b: got %h after %0d edges, need %h after 4",
                     a, b, bin, {bout4, diff4}, lat, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy8, done8, bout8, diff8} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset8: got %h, need 0", {busy8, done8, bout8, diff8});
        end
        vectors++;
        if ({busy4, done4, bout4, diff4} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset4: got %h, need 0", {busy4, done4, bout4, diff4});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        op8(8'd100, 8'd58, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        op8(8'h00, 8'h01, 1'b0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0);
        op8(8'h05, 8'h05, 1'b0, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        logic [8:0] held;
        int extra;
        op8(8'd200, 8'd73, 1'b0, 1'b1);
        held = {bout8, diff8};
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0 || {bout8, diff8} !== 9'h07F || held !== 9'h07F) begin
            miscompares++;
            $display("FAIL ignore_start: got %0d busy/done cycles, result %h, need 0 and 07f",
                     extra, {bout8, diff8});
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        a8 = 8'd9; b8 = 8'd2; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy8, done8, bout8, diff8} !== 11'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got %h, need 0", {busy8, done8, bout8, diff8});
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (ovf8 !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ovf: got %b, need 0", ovf8);
        end
`endif
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL mid_reset_done: got %0d done pulses, need 0", dones);
        end
        op8(8'd7, 8'd3, 1'b0, 1'b0);
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        op8(8'h80, 8'h01, 1'b0, 1'b0);
        op8(8'h10, 8'h01, 1'b0, 1'b0);
        op8(8'h7F, 8'h80, 1'b1, 1'b0);
        op8(8'h80, 8'h80, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++)
                    op4(4'(i), 4'(j), 1'(k));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_start();
        test_mid_reset();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
